alu16_issue_ctrl: RTL

- Command buffer and issue sequencer that sits directly upstream of the 16-bit multi-cycle ALU.
- Accepts tagged operations from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Issues one operation at a time to the ALU, holding operands and opcode stable until the ALU reports not-busy.
- Captures the ALU result and returns it, with its tag, over a second valid/ready handshake.

---
 rtl/alu16_issue_ctrl_if.sv | 28 ++
 rtl/alu16_issue_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu16_issue_ctrl_if.sv
// Producer command and consumer result handshakes of the ALU issue controller.
// The design uses the slave modport; a driver or bench uses the master modport.
interface alu16_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [15:0]      cmd_a;
  logic [15:0]      cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, res_ready,
    input  cmd_ready, res_valid, res_data, res_tag, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, res_ready,
    output cmd_ready, res_valid, res_data, res_tag, res_err
  );
endinterface

// File: rtl/alu16_issue_ctrl.sv
// Command FIFO and one-at-a-time issue sequencer in front of the 16-bit
// multi-cycle ALU; holds operands stable until the ALU drops busy.
module alu16_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                       CK,
  input  logic                       RST,
  alu16_issue_ctrl_if.slave          bus,
  output logic [15:0]                alu_r1,
  output logic [15:0]                alu_r2,
  output logic [2:0]                 alu_instr,
  input  logic                       alu_busy,
  input  logic [15:0]                alu_result,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 3 + 16 + 16 + TAG_W;
  localparam int MAXC  = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CTR_W = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]        alu_r1_q, alu_r1_d;
  logic [15:0]        alu_r2_q, alu_r2_d;
  logic [2:0]         alu_instr_q, alu_instr_d;
  logic [TAG_W-1:0]   pend_tag_q, pend_tag_d;
  logic               res_valid_q, res_valid_d;
  logic [15:0]        res_data_q, res_data_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic               res_err_q, res_err_d;

  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [ENT_W-1:0]   head;
  logic               push;
  logic               pop;
  logic               not_full;

  // Readiness comes only from the registered count, so a pop in the same
  // cycle never lets a push into a full FIFO.
  assign not_full = (count_q != CNT_W'(DEPTH));
  assign push     = bus.cmd_valid && not_full;
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge CK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_tag};
    end
  end

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    alu_r1_d    = alu_r1_q;
    alu_r2_d    = alu_r2_q;
    alu_instr_d = alu_instr_q;
    pend_tag_d  = pend_tag_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          {alu_instr_d, alu_r1_d, alu_r2_d, pend_tag_d} = head;
          ctr_d   = CTR_W'(SETTLE);
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // Busy is not trusted yet: the ALU's busy flag lags the new operands.
        if (ctr_q <= CTR_W'(1)) begin
          ctr_d   = '0;
          state_d = WAIT;
        end else begin
          ctr_d = ctr_q - CTR_W'(1);
        end
      end
      WAIT: begin
        ctr_d = ctr_q + CTR_W'(1);
        if (!alu_busy || (ctr_q == CTR_W'(TIMEOUT - 1))) begin
          res_data_d  = alu_result;
          res_tag_d   = pend_tag_q;
          res_err_d   = alu_busy;
          res_valid_d = 1'b1;
          ctr_d       = '0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q     <= IDLE;
      ctr_q       <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      alu_r1_q    <= '0;
      alu_r2_q    <= '0;
      alu_instr_q <= '0;
      pend_tag_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      alu_r1_q    <= alu_r1_d;
      alu_r2_q    <= alu_r2_d;
      alu_instr_q <= alu_instr_d;
      pend_tag_q  <= pend_tag_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_err_q   <= res_err_d;
    end
  end

  assign bus.cmd_ready = not_full;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.res_err   = res_err_q;
  assign alu_r1        = alu_r1_q;
  assign alu_r2        = alu_r2_q;
  assign alu_instr     = alu_instr_q;
  assign fifo_count    = count_q;
endmodule
